// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter generator: FSM states,
// instruction size and the word-alignment mask.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int         INSN_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: request handshake to instruction memory plus
// redirect/trap/halt/predecode inputs. The master modport is the pc_gen side.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN = 32
);
  // Handshake: a fetch of pc transfers on a cycle where req_valid && req_ready;
  // pc stays stable while req_valid && !req_ready, unless a trap or redirect
  // abandons the outstanding request.
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            halt;
  logic            misalign;
  logic            ras_push;
  logic            ras_pop;
  pc_state_e       state;

  modport master (
    output req_valid, pc, pc_plus4, misalign, state,
    input  req_ready, redirect, redirect_addr, trap, trap_vec, halt,
           ras_push, ras_pop
  );

  modport slave (
    input  req_valid, pc, pc_plus4, misalign, state,
    output req_ready, redirect, redirect_addr, trap, trap_vec, halt,
           ras_push, ras_pop
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest
// entry, a pop on an empty stack is ignored, pop+push replaces the top.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_sp;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_top_idx;
  logic            w_pop;

  assign o_empty   = (r_cnt == '0);
  assign w_pop     = i_pop && !o_empty;
  assign w_top_idx = r_sp - PW'(1);
  assign o_top     = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (w_pop && !i_push) begin
      r_sp  <= r_sp - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end else if (i_push && !w_pop) begin
      r_sp  <= r_sp + PW'(1);
      if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!i_clear) begin
      if (w_pop && i_push) r_mem[w_top_idx] <= i_data;
      else if (i_push)     r_mem[r_sp]      <= i_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > redirect > halt > RAS pop > increment > stall.
// Optional return-address stack compiled in with `define PC_RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);
  pc_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_misalign, w_misalign_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_trap_tgt;
  logic            w_aligned;
  logic            w_ras_push, w_ras_pop, w_ras_clear;
  logic            w_ras_empty;
  logic [XLEN-1:0] w_ras_top;

  assign w_pc_plus4 = r_pc + XLEN'(INSN_BYTES);
  assign w_trap_tgt = {bus.trap_vec[XLEN-1:2], 2'b00};
  assign w_aligned  = (bus.redirect_addr[1:0] & ALIGN_MASK) == 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_misalign_nxt = 1'b0;
    w_ras_push     = 1'b0;
    w_ras_pop      = 1'b0;
    w_ras_clear    = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.trap) begin
          w_pc_nxt    = w_trap_tgt;
          w_ras_clear = 1'b1;
        end else if (bus.redirect && w_aligned) begin
          w_pc_nxt = bus.redirect_addr;
        end else if (bus.redirect) begin
          w_misalign_nxt = 1'b1;
        end else begin
          w_ras_push = bus.ras_push && bus.req_ready;
          if (bus.halt) begin
            w_state_nxt = ST_HALT;
          end else if (bus.ras_pop && !w_ras_empty && bus.req_ready) begin
            w_pc_nxt  = w_ras_top;
            w_ras_pop = 1'b1;
          end else if (bus.req_ready) begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end
      ST_HALT: begin
        if (bus.trap) begin
          w_pc_nxt    = w_trap_tgt;
          w_state_nxt = ST_RUN;
          w_ras_clear = 1'b1;
        end else if (bus.redirect && w_aligned) begin
          w_pc_nxt    = bus.redirect_addr;
          w_state_nxt = ST_RUN;
        end else if (bus.redirect) begin
          w_misalign_nxt = 1'b1;
        end else if (!bus.halt) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

`ifdef PC_RAS_EN
  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_clear (w_ras_clear),
    .i_data  (w_pc_plus4),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );
  logic [1:0] w_unused_vec;
  assign w_unused_vec = bus.trap_vec[1:0];
`else
  // Without the stack the pop path is permanently dead.
  assign w_ras_empty = 1'b1;
  assign w_ras_top   = '0;
  logic        w_unused_ras;
  logic [31:0] w_unused_depth;
  assign w_unused_ras   = ^{bus.ras_push, bus.ras_pop, w_ras_push, w_ras_pop,
                            w_ras_clear, bus.trap_vec[1:0]};
  assign w_unused_depth = 32'(RAS_DEPTH);
`endif

  assign bus.req_valid = (r_state == ST_RUN);
  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.misalign  = r_misalign;
  assign bus.state     = r_state;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage: the successor to the fixed 32-bit, branch-or-increment PC register. It holds the fetch PC and handshakes each fetch request with instruction memory. It prioritises trap entry, redirect (branch/jump/mret) and halt over sequential increment, and checks redirect targets for misalignment. A return-address stack is compiled in optionally. It sits between the execute/CSR redirect logic and the instruction-memory port.

## Interface
- XLEN, 32, address width (≥16, multiple of 8)
- RESET_VEC, 0, PC value loaded by reset (XLEN bits, word-aligned)
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16; unused without PC_RAS_EN)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  out  1  fetch request valid
- req_ready  in  1  instruction memory accepts request this cycle
- pc  out  XLEN  current fetch address
- pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN
- redirect  in  1  branch/jump/mret taken
- redirect_addr  in  XLEN  redirect target
- trap  in  1  trap entry
- trap_vec  in  XLEN  trap handler address (bits [1:0] ignored, forced 0)
- halt  in  1  stop fetching (debug/WFI)
- misalign  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0
- ras_push  in  1  predecode: call seen at pc (push pc_plus4)
- ras_pop  in  1  predecode: return seen at pc (predict from stack)

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT, pc = RESET_VEC, req_valid = 0, misalign = 0, RAS empty.
- BOOT → RUN unconditionally after one cycle. req_valid = 0 in BOOT, pc held.
- RUN: req_valid = 1. Next-PC priority, highest first:
  1. trap → {trap_vec[XLEN-1:2],2'b00}
  2. redirect, aligned → redirect_addr
  3. redirect, misaligned → pc held, misalign pulses next cycle
  4. halt → pc held, go HALT
  5. PC_RAS_EN, ras_pop, stack non-empty, req_ready → stack top (popped)
  6. req_ready → pc_plus4
  7. otherwise → pc held (memory stall)
- Trap and redirect are taken regardless of req_ready; the outstanding request is abandoned.
- HALT: req_valid = 0, pc held. Trap → trap target, RUN. Aligned redirect → target, RUN. halt deasserted → RUN, pc unchanged. A misaligned redirect in HALT pulses misalign and stays in HALT.
- Trap and halt asserted together: trap wins, state RUN.
- Arithmetic: all PC sums are XLEN bits and wrap. 2^XLEN−4 increments to 0 with no flag.

## Timing
- Registered pc; req_valid, pc_plus4 depend only on state/pc (no input→output combinational path except none).
- Redirect/trap sampled at edge N → pc = target after edge N; request issued the same cycle (RUN).
- misalign: registered, high exactly one cycle after the offending edge.
- rst asserted mid-operation: immediate pc = RESET_VEC, BOOT, RAS cleared, misalign low; effective without a clock edge.

## Configuration
- PC_RAS_EN defined: the RAS_DEPTH-entry circular return-address stack is active.
  - Push on ras_push && req_ready in RUN with no trap/redirect; full stack overwrites the oldest entry.
  - Pop per priority 5; pop on empty is ignored (sequential fetch).
  - Push and pop in the same cycle: pop first (prediction uses the old top), then push.
  - Trap clears the stack; a redirect does not.
- PC_RAS_EN undefined: ras_push/ras_pop are ignored, no stack storage is built, and priority 5 does not exist.

## Structure
- Shared package pc_pkg: state enum (BOOT/RUN/HALT), constant for instruction size 4, and an alignment-mask constant.
- Sub-module pc_ras (push, pop, clear, top, empty; parameter RAS_DEPTH, XLEN) holds the stack pointer and count. It is instantiated only under PC_RAS_EN.

## Test plan
- Reset, XLEN=32, RESET_VEC=0x1000, req_ready=1 → pc 0x1000, req_valid 0 for one cycle, then pc 0x1004, 0x1008 on successive edges.
- req_ready low for 3 cycles at pc 0x2000 → pc holds 0x2000, req_valid stays 1; after release → 0x2004.
- redirect to 0x3002 → misalign pulse one cycle, pc unchanged. Trap (trap_vec 0x8003) with redirect to 0x4000 in the same cycle → pc 0x8000.
- halt at pc 0x500 → req_valid 0, pc 0x500 held. Trap while halted → pc = trap target, RUN. halt released (no trap) → fetch resumes at 0x500.
- pc 0xFFFFFFFC, req_ready=1 → pc wraps to 0x00000000. Assert rst asynchronously mid-run → pc = RESET_VEC before the next edge.
- PC_RAS_EN: push at pc 0x100 (stores 0x104), later pop → pc 0x104. With RAS_DEPTH=4, 5 pushes then 5 pops → first 4 pops return in LIFO order, the 5th falls back to pc_plus4.
